// File: rtl/dma_mm2s_ctrl.sv
// MM2S channel controller: issues 4 KB-safe AXI4 INCR read bursts from the
// source-address/length registers and forwards the read data onto an AXI stream.
module dma_mm2s_ctrl #(
    parameter int unsigned MAX_BURST = 16,
    parameter int unsigned LEN_W     = 26
) (
    input  logic        m_axi_mm2s_aclk,
    input  logic        axi_reset,
    input  logic [31:0] mm2s_dmacr,
    input  logic [31:0] mm2s_sa,
    input  logic [31:0] mm2s_length,
    input  logic        mm2s_length_wr,
    input  logic        mm2s_dmasr_wr,
    input  logic [31:0] mm2s_dmasr_wdata,
    output logic [31:0] mm2s_dmasr,
    output logic        mm2s_introut,
    output logic [31:0] m_axi_mm2s_araddr,
    output logic [7:0]  m_axi_mm2s_arlen,
    output logic [2:0]  m_axi_mm2s_arsize,
    output logic [1:0]  m_axi_mm2s_arburst,
    output logic [3:0]  m_axi_mm2s_arcache,
    output logic [2:0]  m_axi_mm2s_arprot,
    output logic        m_axi_mm2s_arvalid,
    input  logic        m_axi_mm2s_arready,
    input  logic [31:0] m_axi_mm2s_rdata,
    input  logic [1:0]  m_axi_mm2s_rresp,
    input  logic        m_axi_mm2s_rlast,
    input  logic        m_axi_mm2s_rvalid,
    output logic        m_axi_mm2s_rready,
    output logic [31:0] m_axis_mm2s_tdata,
    output logic [3:0]  m_axis_mm2s_tkeep,
    output logic        m_axis_mm2s_tlast,
    output logic        m_axis_mm2s_tvalid,
    input  logic        m_axis_mm2s_tready
);

    typedef enum logic [2:0] {
        ST_HALT, ST_IDLE, ST_AR, ST_DATA, ST_DRAIN, ST_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       addr_q, addr_d;
    logic [1:0]        tail_q, tail_d;
    logic [LEN_W-1:0]  words_q, words_d;
    logic [8:0]        beats_q, beats_d;
    logic              int_err_q, int_err_d;
    logic              slv_err_q, slv_err_d;
    logic              dec_err_q, dec_err_d;
    logic              ioc_irq_q, ioc_irq_d;
    logic              err_irq_q, err_irq_d;
    logic              introut_q, introut_d;

    logic              rs;
    logic [LEN_W-1:0]  len_bytes;
    logic [LEN_W:0]    len_sum;
    logic [12:0]       page_room;
    logic [31:0]       words32, page32, beats32;
    logic [8:0]        burst_beats, arlen_full;
    logic              last_word, r_err, set_ioc, set_err;
    logic              unused_ok;

    assign rs        = mm2s_dmacr[0];
    assign len_bytes = mm2s_length[LEN_W-1:0];
    assign len_sum   = {1'b0, len_bytes} + {{(LEN_W-1){1'b0}}, 2'b11};
    assign page_room = 13'h1000 - {1'b0, addr_q[11:0]};
    assign words32   = 32'(words_q);
    assign page32    = {21'd0, page_room[12:2]};

    // Burst length is the tightest of words left, MAX_BURST and room to the 4 KB page end
    always_comb begin
        beats32 = 32'(MAX_BURST);
        if (page32 < beats32) beats32 = page32;
        if (words32 < beats32) beats32 = words32;
    end

    assign burst_beats = beats32[8:0];
    assign arlen_full  = burst_beats - 9'd1;
    assign last_word   = (words_q == LEN_W'(1));
    assign r_err       = (m_axi_mm2s_rresp != 2'b00);

    assign m_axi_mm2s_araddr  = addr_q;
    assign m_axi_mm2s_arlen   = arlen_full[7:0];
    assign m_axi_mm2s_arsize  = 3'b010;
    assign m_axi_mm2s_arburst = 2'b01;
    assign m_axi_mm2s_arcache = 4'b0011;
    assign m_axi_mm2s_arprot  = 3'b000;
    assign m_axis_mm2s_tdata  = m_axi_mm2s_rdata;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        tail_d    = tail_q;
        words_d   = words_q;
        beats_d   = beats_q;
        int_err_d = int_err_q;
        slv_err_d = slv_err_q;
        dec_err_d = dec_err_q;
        set_ioc   = 1'b0;
        set_err   = 1'b0;
        m_axi_mm2s_arvalid = 1'b0;
        m_axi_mm2s_rready  = 1'b0;
        m_axis_mm2s_tvalid = 1'b0;
        m_axis_mm2s_tlast  = 1'b0;
        m_axis_mm2s_tkeep  = 4'hF;

        case (state_q)
            ST_HALT: begin
                if (rs) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (!rs) begin
                    state_d = ST_HALT;
                end else if (mm2s_length_wr) begin
                    addr_d  = mm2s_sa;
                    tail_d  = len_bytes[1:0];
                    words_d = {1'b0, len_sum[LEN_W:2]};
                    if (len_bytes == '0 || mm2s_sa[1:0] != 2'b00) begin
                        int_err_d = 1'b1;
                        set_err   = 1'b1;
                        state_d   = ST_ERR;
                    end else begin
                        state_d = ST_AR;
                    end
                end
            end
            ST_AR: begin
                m_axi_mm2s_arvalid = 1'b1;
                if (m_axi_mm2s_arready) begin
                    beats_d = burst_beats;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                m_axi_mm2s_rready  = m_axis_mm2s_tready;
                m_axis_mm2s_tvalid = m_axi_mm2s_rvalid;
                m_axis_mm2s_tlast  = m_axi_mm2s_rvalid & (last_word | r_err);
                if (last_word) begin
                    case (tail_q)
                        2'd1:    m_axis_mm2s_tkeep = 4'h1;
                        2'd2:    m_axis_mm2s_tkeep = 4'h3;
                        2'd3:    m_axis_mm2s_tkeep = 4'h7;
                        default: m_axis_mm2s_tkeep = 4'hF;
                    endcase
                end
                if (m_axi_mm2s_rvalid && m_axis_mm2s_tready) begin
                    words_d = words_q - LEN_W'(1);
                    if (r_err) begin
                        set_err = 1'b1;
                        if (m_axi_mm2s_rresp == 2'b11) dec_err_d = 1'b1;
                        else                           slv_err_d = 1'b1;
                        state_d = m_axi_mm2s_rlast ? ST_ERR : ST_DRAIN;
                    end else if (m_axi_mm2s_rlast) begin
                        if (last_word) begin
                            set_ioc = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            addr_d  = addr_q + {21'd0, beats_q, 2'b00};
                            state_d = rs ? ST_AR : ST_HALT;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                m_axi_mm2s_rready = 1'b1;
                if (m_axi_mm2s_rvalid && m_axi_mm2s_rlast) state_d = ST_ERR;
            end
            ST_ERR: begin
                state_d = ST_ERR;
            end
            default: state_d = ST_HALT;
        endcase

        // A set event in the same cycle wins over a W1C clear
        ioc_irq_d = (ioc_irq_q & ~(mm2s_dmasr_wr & mm2s_dmasr_wdata[12])) | set_ioc;
        err_irq_d = (err_irq_q & ~(mm2s_dmasr_wr & mm2s_dmasr_wdata[14])) | set_err;
        introut_d = (ioc_irq_q & mm2s_dmacr[12]) | (err_irq_q & mm2s_dmacr[14]);
    end

    always_ff @(posedge m_axi_mm2s_aclk or posedge axi_reset) begin
        if (axi_reset) begin
            state_q   <= ST_HALT;
            addr_q    <= '0;
            tail_q    <= '0;
            words_q   <= '0;
            beats_q   <= '0;
            int_err_q <= 1'b0;
            slv_err_q <= 1'b0;
            dec_err_q <= 1'b0;
            ioc_irq_q <= 1'b0;
            err_irq_q <= 1'b0;
            introut_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            tail_q    <= tail_d;
            words_q   <= words_d;
            beats_q   <= beats_d;
            int_err_q <= int_err_d;
            slv_err_q <= slv_err_d;
            dec_err_q <= dec_err_d;
            ioc_irq_q <= ioc_irq_d;
            err_irq_q <= err_irq_d;
            introut_q <= introut_d;
        end
    end

    assign mm2s_dmasr = {17'd0, err_irq_q, 1'b0, ioc_irq_q, 5'd0, dec_err_q, slv_err_q,
                         int_err_q, 2'b00, (state_q == ST_IDLE),
                         (state_q == ST_HALT) || (state_q == ST_ERR)};
    assign mm2s_introut = introut_q;

    assign unused_ok = ^{mm2s_dmacr, mm2s_length, mm2s_dmasr_wdata, beats32,
                         arlen_full, page_room, len_sum};

endmodule
